// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the two-port memory arbiter.
// The arbiter binds to the slave modport; the surrounding system drives through master.
interface mem_arbiter_if;
   logic        req0, req1;
   logic        we0, we1;
   logic        byte0, byte1;
   logic [15:0] addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic        gnt0, gnt1;
   logic        ack0, ack1;
   logic        err0, err1;
   logic [15:0] rdata0, rdata1;
   logic        mem_en;
   logic        mem_we;
   logic        mem_byte_enable;
   logic        mem_byte_select;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_wait;

   modport slave (
      input  req0, req1, we0, we1, byte0, byte1, addr0, addr1, wdata0, wdata1,
      output gnt0, gnt1, ack0, ack1, err0, err1, rdata0, rdata1,
      output mem_en, mem_we, mem_byte_enable, mem_byte_select, mem_addr, mem_wdata,
      input  mem_rdata, mem_wait
   );

   modport master (
      output req0, req1, we0, we1, byte0, byte1, addr0, addr1, wdata0, wdata1,
      input  gnt0, gnt1, ack0, ack1, err0, err1, rdata0, rdata1,
      input  mem_en, mem_we, mem_byte_enable, mem_byte_select, mem_addr, mem_wdata,
      output mem_rdata, mem_wait
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing a single-ported memory between the CPU (port 0) and a
// secondary master (port 1), with a starvation counter that force-grants port 1.
module mem_arbiter #(
   parameter int MEM_BYTES = 16384,
   parameter int MAX_WAIT  = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.slave  bus
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DATA   = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   localparam logic [3:0]  MAX_W = 4'(MAX_WAIT);
   localparam logic [16:0] LIMIT = 17'(MEM_BYTES);

   logic [1:0]  state_q, state_d;
   logic [3:0]  starve_q, starve_d;
   logic        port_q, port_d;
   logic        we_q, we_d;
   logic        byte_q, byte_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        err_q, err_d;
   logic [15:0] rdata_q, rdata_d;

   logic        win1;
   logic        sel_we, sel_byte;
   logic [15:0] sel_addr, sel_wdata;

   // Port 0 wins by default; port 1 takes over when port 0 is idle or starvation saturates.
   assign win1      = bus.req1 && (!bus.req0 || (starve_q == MAX_W));
   assign sel_we    = win1 ? bus.we1    : bus.we0;
   assign sel_byte  = win1 ? bus.byte1  : bus.byte0;
   assign sel_addr  = win1 ? bus.addr1  : bus.addr0;
   assign sel_wdata = win1 ? bus.wdata1 : bus.wdata0;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d  = state_q;
      starve_d = starve_q;
      port_d   = port_q;
      we_d     = we_q;
      byte_d   = byte_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      rdata_d  = rdata_q;

      case (state_q)
         IDLE: begin
            if (!bus.req1 || win1) begin
               starve_d = '0;
            end else if (starve_q != MAX_W) begin
               starve_d = starve_q + 4'd1;
            end
            if (bus.req0 || bus.req1) begin
               port_d  = win1;
               we_d    = sel_we;
               byte_d  = sel_byte;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               rdata_d = '0;
               err_d   = ({1'b0, sel_addr} >= LIMIT);
               state_d = ({1'b0, sel_addr} >= LIMIT) ? RESP : ACCESS;
            end
         end
         ACCESS: state_d = DATA;
         DATA: begin
            if (!bus.mem_wait) begin
               rdata_d = we_q ? 16'h0000 : bus.mem_rdata;
               state_d = RESP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_n) begin
         state_q  <= IDLE;
         starve_q <= '0;
         port_q   <= 1'b0;
         we_q     <= 1'b0;
         byte_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         port_q   <= port_d;
         we_q     <= we_d;
         byte_q   <= byte_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   logic mem_phase, in_access, in_resp;
   assign mem_phase = (state_q == ACCESS) || (state_q == DATA);
   assign in_access = (state_q == ACCESS);
   assign in_resp   = (state_q == RESP);

   // A rejected request skips ACCESS, so its grant coincides with the ack.
   assign bus.gnt0   = (in_access || (in_resp && err_q)) && !port_q;
   assign bus.gnt1   = (in_access || (in_resp && err_q)) &&  port_q;
   assign bus.ack0   = in_resp && !port_q;
   assign bus.ack1   = in_resp &&  port_q;
   assign bus.err0   = in_resp && !port_q && err_q;
   assign bus.err1   = in_resp &&  port_q && err_q;
   assign bus.rdata0 = (in_resp && !port_q) ? rdata_q : 16'h0000;
   assign bus.rdata1 = (in_resp &&  port_q) ? rdata_q : 16'h0000;

   assign bus.mem_en          = mem_phase;
   assign bus.mem_we          = mem_phase && we_q;
   assign bus.mem_byte_enable = mem_phase && byte_q;
   assign bus.mem_byte_select = mem_phase && addr_q[0];
   assign bus.mem_addr        = mem_phase ? {1'b0, addr_q[15:1]} : 16'h0000;
   assign bus.mem_wdata       = mem_phase ? wdata_q : 16'h0000;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: read, byte write, wait states, range reject,
// mid-access reset and starvation force-grant, with hand-computed expectations.
module tb_mem_arbiter;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   mem_arbiter_if bus ();

   mem_arbiter #(.MEM_BYTES(16384), .MAX_WAIT(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Packs every DUT output of one port so "all zero" is a single comparison.
   function automatic logic [31:0] p0_all();
      return {13'd0, bus.gnt0, bus.ack0, bus.err0, bus.rdata0};
   endfunction
   function automatic logic [31:0] p1_all();
      return {13'd0, bus.gnt1, bus.ack1, bus.err1, bus.rdata1};
   endfunction
   function automatic logic [31:0] mem_all();
      return {bus.mem_en, bus.mem_we, bus.mem_byte_enable, bus.mem_byte_select,
              bus.mem_addr[11:0], bus.mem_wdata};
   endfunction

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
      bus.byte0 = 0; bus.byte1 = 0; bus.addr0 = '0; bus.addr1 = '0;
      bus.wdata0 = '0; bus.wdata1 = '0; bus.mem_rdata = '0; bus.mem_wait = 0;

      // Reset state
      step(); step();
      check("rst_p0", p0_all(), 0);
      check("rst_p1", p1_all(), 0);
      check("rst_mem", mem_all(), 0);
      check("rst_mem_addr", {16'd0, bus.mem_addr}, 0);
      rst_n = 1'b1;
      step();

      // Port 0 word read at 0x0010
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0010;
      step();
      check("rd_gnt0", {31'd0, bus.gnt0}, 1);
      check("rd_mem_en", {31'd0, bus.mem_en}, 1);
      check("rd_mem_we", {31'd0, bus.mem_we}, 0);
      check("rd_mem_addr", {16'd0, bus.mem_addr}, 32'h0008);
      check("rd_p1_gnt", p1_all(), 0);
      bus.req0 = 0; bus.mem_rdata = 16'hBEEF;
      step();
      check("rd_data_en", {31'd0, bus.mem_en}, 1);
      check("rd_data_gnt0", {31'd0, bus.gnt0}, 0);
      check("rd_data_ack0", {31'd0, bus.ack0}, 0);
      step();
      check("rd_ack0", {31'd0, bus.ack0}, 1);
      check("rd_rdata0", {16'd0, bus.rdata0}, 32'hBEEF);
      check("rd_err0", {31'd0, bus.err0}, 0);
      check("rd_resp_mem_en", {31'd0, bus.mem_en}, 0);
      check("rd_p1_resp", p1_all(), 0);
      step();
      check("rd_idle_p0", p0_all(), 0);

      // Port 1 byte write at odd address 0x0123
      bus.req1 = 1; bus.we1 = 1; bus.byte1 = 1; bus.addr1 = 16'h0123; bus.wdata1 = 16'h00AA;
      step();
      check("bw_gnt1", {31'd0, bus.gnt1}, 1);
      check("bw_p0", p0_all(), 0);
      check("bw_mem", mem_all(), {4'b1111, 12'h091, 16'h00AA});
      check("bw_mem_addr", {16'd0, bus.mem_addr}, 32'h0091);
      bus.req1 = 0; bus.mem_rdata = 16'h5555;
      step();
      step();
      check("bw_ack1", {31'd0, bus.ack1}, 1);
      check("bw_rdata1", {16'd0, bus.rdata1}, 0);
      check("bw_err1", {31'd0, bus.err1}, 0);
      check("bw_ack0", {31'd0, bus.ack0}, 0);
      step();
      bus.we1 = 0; bus.byte1 = 0;

      // Port 0 read with three wait cycles in DATA
      bus.req0 = 1; bus.addr0 = 16'h0201; bus.mem_wait = 1; bus.mem_rdata = 16'hDEAD;
      step();
      check("ws_gnt0", {31'd0, bus.gnt0}, 1);
      check("ws_bsel", {31'd0, bus.mem_byte_select}, 1);
      check("ws_benable", {31'd0, bus.mem_byte_enable}, 0);
      bus.req0 = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("ws_en", {31'd0, bus.mem_en}, 1);
         check("ws_addr", {16'd0, bus.mem_addr}, 32'h0100);
         check("ws_noack", {31'd0, bus.ack0}, 0);
      end
      bus.mem_wait = 0; bus.mem_rdata = 16'h1234;
      step();
      check("ws_ack0", {31'd0, bus.ack0}, 1);
      check("ws_rdata0", {16'd0, bus.rdata0}, 32'h1234);
      step();

      // Out-of-range request on port 1 and top in-range byte on port 0
      bus.req1 = 1; bus.addr1 = 16'h4000;
      step();
      check("oor_gnt1", {31'd0, bus.gnt1}, 1);
      check("oor_ack1", {31'd0, bus.ack1}, 1);
      check("oor_err1", {31'd0, bus.err1}, 1);
      check("oor_rdata1", {16'd0, bus.rdata1}, 0);
      check("oor_mem_en", {31'd0, bus.mem_en}, 0);
      bus.req1 = 0;
      step();
      check("oor_idle_p1", p1_all(), 0);
      bus.req0 = 1; bus.byte0 = 1; bus.addr0 = 16'h3FFF; bus.mem_rdata = 16'h00C3;
      step();
      check("top_gnt0", {31'd0, bus.gnt0}, 1);
      check("top_mem", mem_all(), {4'b1011, 12'hFFF, 16'h0000});
      bus.req0 = 0; bus.byte0 = 0;
      step(); step();
      check("top_ack0", {31'd0, bus.ack0}, 1);
      check("top_err0", {31'd0, bus.err0}, 0);
      check("top_rdata0", {16'd0, bus.rdata0}, 32'h00C3);
      step();

      // Reset in the middle of DATA
      bus.req0 = 1; bus.addr0 = 16'h0002; bus.mem_wait = 1;
      step();
      bus.req0 = 0;
      step();
      check("mr_in_data", {31'd0, bus.mem_en}, 1);
      rst_n = 1'b0;
      step();
      check("mr_p0", p0_all(), 0);
      check("mr_mem", mem_all(), 0);
      rst_n = 1'b1; bus.mem_wait = 0;
      step();
      check("mr_idle_p0", p0_all(), 0);
      check("mr_idle_en", {31'd0, bus.mem_en}, 0);
      bus.req0 = 1; bus.addr0 = 16'h0004; bus.mem_rdata = 16'hCAFE;
      step();
      check("mr_gnt0", {31'd0, bus.gnt0}, 1);
      check("mr_addr", {16'd0, bus.mem_addr}, 32'h0002);
      bus.req0 = 0;
      step(); step();
      check("mr_ack0", {31'd0, bus.ack0}, 1);
      check("mr_rdata0", {16'd0, bus.rdata0}, 32'hCAFE);
      step();

      // Starvation: both ports request continuously; 9th arbitration goes to port 1
      bus.req0 = 1; bus.req1 = 1; bus.addr0 = 16'h0020; bus.addr1 = 16'h0040;
      for (int i = 0; i < 10; i++) begin
         step();
         check($sformatf("sv_gnt0_%0d", i), {31'd0, bus.gnt0}, (i == 8) ? 0 : 1);
         check($sformatf("sv_gnt1_%0d", i), {31'd0, bus.gnt1}, (i == 8) ? 1 : 0);
         check($sformatf("sv_addr_%0d", i), {16'd0, bus.mem_addr}, (i == 8) ? 32'h0020 : 32'h0010);
         step(); step(); step();
      end
      bus.req0 = 0; bus.req1 = 0;
      step();
      check("sv_end_p0", p0_all(), 0);
      check("sv_end_p1", p1_all(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
